// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

   // Owner of the access issued in the previous cycle
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_t;

   // Instruction fetches are always full-word accesses
   localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory side signals of the arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [2:0]        d_funct3;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_stall;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_funct3;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter view
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
      output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
   );

   // Requesters and memory view
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
      input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
   );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of contested data wins
module mem_port_arbiter_starve_counter #(
   parameter int MAX_STARVE = 4,
   parameter int CW         = $clog2(MAX_STARVE + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt
);

   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

   // Clear wins over increment; increment stops at the starvation limit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and load/store
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STARVE = 4
) (
   input logic             clk,
   input logic             reset,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = $clog2(MAX_STARVE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              if_elig;
   logic              d_elig;
   logic              contested;
   logic              starve_hit;
   logic              grant_if;
   logic              grant_d;
   logic [CW-1:0]     starve_cnt;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;

   // Eligibility and grant: data wins a contest unless fetch has waited its limit
   always_comb begin
      if_elig    = bus.if_req && (state != BUSY_IF);
      d_elig     = bus.d_req && (state != BUSY_D);
      contested  = if_elig && d_elig;
      starve_hit = (starve_cnt == CNT_MAX);
      grant_if   = if_elig && (!d_elig || starve_hit);
      grant_d    = d_elig && (!if_elig || !starve_hit);
   end

   mem_port_arbiter_starve_counter #(
      .MAX_STARVE (MAX_STARVE),
      .CW         (CW)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (contested && grant_d),
      .clr   (grant_if),
      .cnt   (starve_cnt)
   );

   // State records who owns the access whose response lands next cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next owner follows this cycle's grant
   always_comb begin
      state_nxt = IDLE;
      if (grant_if) begin
         state_nxt = BUSY_IF;
      end else if (grant_d) begin
         state_nxt = BUSY_D;
      end
   end

   // Memory request mux; everything zero when nothing is granted
   always_comb begin
      addr_mux       = '0;
      wdata_mux      = '0;
      bus.mem_funct3 = 3'b000;
      bus.mem_we     = 1'b0;
      if (grant_if) begin
         addr_mux       = bus.if_addr;
         bus.mem_funct3 = FUNCT3_WORD;
      end else if (grant_d) begin
         addr_mux       = bus.d_addr;
         wdata_mux      = bus.d_wdata;
         bus.mem_funct3 = bus.d_funct3;
         bus.mem_we     = bus.d_we;
      end
      bus.mem_en    = grant_if || grant_d;
      bus.mem_addr  = addr_mux;
      bus.mem_wdata = wdata_mux;
   end

   // Response steering and stalls toward the pipeline
   always_comb begin
      bus.if_valid = (state == BUSY_IF);
      bus.d_valid  = (state == BUSY_D);
      bus.if_rdata = bus.if_valid ? bus.mem_rdata : '0;
      bus.d_rdata  = bus.d_valid ? bus.mem_rdata : '0;
      bus.if_stall = bus.if_req && !bus.if_valid;
      bus.d_stall  = bus.d_req && !bus.d_valid;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [5:0] ctrl;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {mem_en, mem_we, if_valid, d_valid, if_stall, d_stall}
   assign ctrl = {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid, bus.if_stall, bus.d_stall};

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      settle();
      total++;
      if (ctrl !== 6'b000000) begin
         bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, 6'b000000);
      end
      total++;
      if (dut.state !== IDLE || dut.starve_cnt !== 3'd0) begin
         bad++; $display("FAIL reset_state got=%0d/%0d want=0/0", dut.state, dut.starve_cnt);
      end
      bus.if_req = 1'b1; bus.if_addr = 32'h8;
      #1;
      total++;
      if (ctrl !== 6'b100010 || bus.mem_addr !== 32'h8) begin
         bad++; $display("FAIL reset_comb_grant got=%b/%h want=100010/8", ctrl, bus.mem_addr);
      end
      bus.if_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_fetch_only();
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      settle();
      total++;
      if (ctrl !== 6'b100010 || bus.mem_addr !== 32'h10 || bus.mem_funct3 !== 3'b010) begin
         bad++; $display("FAIL fetch_c0 got=%b/%h/%b want=100010/10/010", ctrl, bus.mem_addr, bus.mem_funct3);
      end
      tick();
      bus.mem_rdata = 32'h00500093;
      settle();
      total++;
      if (ctrl !== 6'b001000 || bus.if_rdata !== 32'h00500093) begin
         bad++; $display("FAIL fetch_c1 got=%b/%h want=001000/00500093", ctrl, bus.if_rdata);
      end
      total++;
      if (bus.d_rdata !== 32'h0) begin
         bad++; $display("FAIL fetch_c1_drdata got=%h want=0", bus.d_rdata);
      end
      tick();
      bus.mem_rdata = 32'h0;
      settle();
      total++;
      if (ctrl !== 6'b100010 || bus.if_rdata !== 32'h0) begin
         bad++; $display("FAIL fetch_c2_regrant got=%b/%h want=100010/0", ctrl, bus.if_rdata);
      end
      tick();
      settle();
      total++;
      if (ctrl !== 6'b001000) begin
         bad++; $display("FAIL fetch_c3 got=%b want=001000", ctrl);
      end
      tick();
      bus.if_req = 1'b0;
      tick();
   endtask

   task automatic test_contested();
      bus.if_req = 1'b1; bus.if_addr = 32'h20;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_funct3 = 3'b100;
      settle();
      total++;
      if (ctrl !== 6'b100011 || bus.mem_addr !== 32'h40 || bus.mem_funct3 !== 3'b100) begin
         bad++; $display("FAIL cont_c0 got=%b/%h/%b want=100011/40/100", ctrl, bus.mem_addr, bus.mem_funct3);
      end
      tick();
      bus.mem_rdata = 32'h11112222;
      settle();
      total++;
      if (ctrl !== 6'b100110 || bus.mem_addr !== 32'h20 || bus.mem_funct3 !== 3'b010) begin
         bad++; $display("FAIL cont_c1 got=%b/%h/%b want=100110/20/010", ctrl, bus.mem_addr, bus.mem_funct3);
      end
      total++;
      if (bus.d_rdata !== 32'h11112222 || bus.mem_wdata !== 32'h0) begin
         bad++; $display("FAIL cont_c1_data got=%h/%h want=11112222/0", bus.d_rdata, bus.mem_wdata);
      end
      tick();
      bus.d_req = 1'b0;
      bus.mem_rdata = 32'h33334444;
      settle();
      total++;
      if (ctrl !== 6'b001000 || bus.if_rdata !== 32'h33334444 || dut.starve_cnt !== 3'd0) begin
         bad++; $display("FAIL cont_c2 got=%b/%h/%0d want=001000/33334444/0", ctrl, bus.if_rdata, dut.starve_cnt);
      end
      tick();
      bus.if_req = 1'b0; bus.mem_rdata = 32'h0;
      tick();
   endtask

   task automatic test_store();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h44;
      bus.d_wdata = 32'hDEADBEEF; bus.d_funct3 = 3'b010;
      settle();
      total++;
      if (ctrl !== 6'b110001 || bus.mem_addr !== 32'h44 || bus.mem_wdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL store_c0 got=%b/%h/%h want=110001/44/deadbeef", ctrl, bus.mem_addr, bus.mem_wdata);
      end
      total++;
      if (bus.mem_funct3 !== 3'b010) begin
         bad++; $display("FAIL store_c0_f3 got=%b want=010", bus.mem_funct3);
      end
      tick();
      settle();
      total++;
      if (ctrl !== 6'b000100) begin
         bad++; $display("FAIL store_c1 got=%b want=000100", ctrl);
      end
      tick();
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 32'h0;
      tick();
   endtask

   task automatic test_starvation();
      bus.if_addr = 32'h30;
      bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_funct3 = 3'b010;
      bus.d_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         // fetch only competes in the cycles where data is eligible too
         bus.if_req = 1'b1;
         settle();
         total++;
         if (ctrl !== 6'b100011 || bus.mem_addr !== 32'h80 || dut.starve_cnt !== 3'(k - 1)) begin
            bad++; $display("FAIL starve_data%0d got=%b/%h/%0d want=100011/80/%0d", k, ctrl, bus.mem_addr, dut.starve_cnt, k - 1);
         end
         tick();
         bus.if_req = 1'b0;
         settle();
         total++;
         if (ctrl !== 6'b000100 || dut.starve_cnt !== 3'(k)) begin
            bad++; $display("FAIL starve_valid%0d got=%b/%0d want=000100/%0d", k, ctrl, dut.starve_cnt, k);
         end
         tick();
      end
      bus.if_req = 1'b1;
      settle();
      total++;
      if (ctrl !== 6'b100011 || bus.mem_addr !== 32'h30) begin
         bad++; $display("FAIL starve_fetch_wins got=%b/%h want=100011/30", ctrl, bus.mem_addr);
      end
      tick();
      settle();
      total++;
      if (ctrl !== 6'b101001 || bus.mem_addr !== 32'h80 || dut.starve_cnt !== 3'd0) begin
         bad++; $display("FAIL starve_after got=%b/%h/%0d want=101001/80/0", ctrl, bus.mem_addr, dut.starve_cnt);
      end
      tick();
      bus.if_req = 1'b0;
      settle();
      total++;
      if (ctrl !== 6'b000100) begin
         bad++; $display("FAIL starve_tail got=%b want=000100", ctrl);
      end
      tick();
      bus.d_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.if_req = 1'b1; bus.if_addr = 32'h60;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50;
      settle();
      total++;
      if (ctrl !== 6'b100011 || bus.mem_addr !== 32'h50) begin
         bad++; $display("FAIL rmid_c0 got=%b/%h want=100011/50", ctrl, bus.mem_addr);
      end
      tick();
      reset = 1'b0;
      settle();
      total++;
      if (bus.d_valid !== 1'b0 || dut.state !== IDLE || dut.starve_cnt !== 3'd0) begin
         bad++; $display("FAIL rmid_dropped got=%b/%0d/%0d want=0/0/0", bus.d_valid, dut.state, dut.starve_cnt);
      end
      total++;
      if (ctrl !== 6'b100011) begin
         bad++; $display("FAIL rmid_comb got=%b want=100011", ctrl);
      end
      bus.if_req = 1'b0;
      tick();
      reset = 1'b1;
      settle();
      total++;
      if (ctrl !== 6'b100001 || bus.mem_addr !== 32'h50) begin
         bad++; $display("FAIL rmid_regrant got=%b/%h want=100001/50", ctrl, bus.mem_addr);
      end
      tick();
      settle();
      total++;
      if (ctrl !== 6'b000100) begin
         bad++; $display("FAIL rmid_valid got=%b want=000100", ctrl);
      end
      tick();
      bus.d_req = 1'b0;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
      bus.d_wdata = '0; bus.d_funct3 = 3'b000; bus.mem_rdata = '0;
      test_reset();
      test_fetch_only();
      test_contested();
      test_store();
      test_starvation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
